cluster_power_seq: RTL

Sequences power-up and power-down of the cluster domain from the SoC side. Drives the cluster power, clock-enable, reset, fetch-enable, bypass and boot-address lines in a fixed order with programmable dwell times. Drains the cluster using cluster_busy before tearing it down. Sits in the SoC domain between the FC-facing control registers and the cluster control outputs.

---
 rtl/cluster_power_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/cluster_power_seq.sv
// Cluster power sequencer: ordered power/clock/reset/fetch bring-up and
// drained teardown of the cluster domain, with programmable dwell times.
module cluster_power_seq #(
    parameter int unsigned PWR_WAIT      = 16,
    parameter int unsigned CLK_WAIT      = 4,
    parameter int unsigned RST_WAIT      = 8,
    parameter int unsigned DRAIN_TIMEOUT = 1024,
    parameter int unsigned CNT_W         = $clog2(
        ((PWR_WAIT > CLK_WAIT) ? PWR_WAIT : CLK_WAIT) >
        ((RST_WAIT > DRAIN_TIMEOUT) ? RST_WAIT : DRAIN_TIMEOUT)
            ? ((PWR_WAIT > CLK_WAIT) ? PWR_WAIT : CLK_WAIT)
            : ((RST_WAIT > DRAIN_TIMEOUT) ? RST_WAIT : DRAIN_TIMEOUT)) + 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pwr_up_req_i,
    input  logic        pwr_dn_req_i,
    input  logic [63:0] boot_addr_i,
    input  logic        byp_i,
    input  logic        cluster_busy_i,
    output logic        cluster_pow_o,
    output logic        cluster_clk_en_o,
    output logic        cluster_rstn_o,
    output logic        cluster_fetch_enable_o,
    output logic [63:0] cluster_boot_addr_o,
    output logic        cluster_byp_o,
    output logic        req_ack_o,
    output logic        done_evt_o,
    output logic        err_o,
    output logic [2:0]  state_o
);

    localparam logic [2:0] S_OFF     = 3'd0;
    localparam logic [2:0] S_PWR_ON  = 3'd1;
    localparam logic [2:0] S_CLK_ON  = 3'd2;
    localparam logic [2:0] S_RST_REL = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;
    localparam logic [2:0] S_DRAIN   = 3'd5;
    localparam logic [2:0] S_RST_ASS = 3'd6;
    localparam logic [2:0] S_PWR_OFF = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      boot_addr_q, boot_addr_d;
    logic             byp_q, byp_d;
    logic             ack_q, ack_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             pow_q, pow_d;
    logic             clk_en_q, clk_en_d;
    logic             rstn_q, rstn_d;
    logic             fetch_q, fetch_d;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_dec;

    assign cnt_zero = (cnt_q == '0);
    assign cnt_dec  = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);

    // Next-state, dwell counter and sampled-register logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        boot_addr_d = boot_addr_q;
        byp_d       = byp_q;
        ack_d       = 1'b0;
        err_d       = err_q;
        case (state_q)
            S_OFF: begin
                if (pwr_up_req_i) begin
                    state_d     = S_PWR_ON;
                    cnt_d       = CNT_W'(PWR_WAIT - 1);
                    ack_d       = 1'b1;
                    boot_addr_d = boot_addr_i;
                    byp_d       = byp_i;
                    err_d       = 1'b0;
                end
            end
            S_PWR_ON: begin
                cnt_d = cnt_dec;
                if (cnt_zero) begin
                    state_d = S_CLK_ON;
                    cnt_d   = CNT_W'(CLK_WAIT - 1);
                end
            end
            S_CLK_ON: begin
                cnt_d = cnt_dec;
                if (cnt_zero) begin
                    state_d = S_RST_REL;
                    cnt_d   = CNT_W'(RST_WAIT - 1);
                end
            end
            S_RST_REL: begin
                cnt_d = cnt_dec;
                if (cnt_zero) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (pwr_dn_req_i) begin
                    state_d = S_DRAIN;
                    cnt_d   = CNT_W'(DRAIN_TIMEOUT - 1);
                    ack_d   = 1'b1;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_dec;
                // An idle cluster beats a simultaneous timeout
                if (!cluster_busy_i) begin
                    state_d = S_RST_ASS;
                    cnt_d   = CNT_W'(RST_WAIT - 1);
                end else if (cnt_zero) begin
                    state_d = S_RST_ASS;
                    cnt_d   = CNT_W'(RST_WAIT - 1);
                    err_d   = 1'b1;
                end
            end
            S_RST_ASS: begin
                cnt_d = cnt_dec;
                if (cnt_zero) begin
                    state_d = S_PWR_OFF;
                    cnt_d   = CNT_W'(PWR_WAIT - 1);
                end
            end
            S_PWR_OFF: begin
                cnt_d = cnt_dec;
                if (cnt_zero) begin
                    state_d = S_OFF;
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    // Output levels registered from the upcoming state
    always_comb begin
        pow_d    = (state_d != S_OFF);
        clk_en_d = (state_d >= S_CLK_ON) && (state_d <= S_RST_ASS);
        rstn_d   = (state_d >= S_RST_REL) && (state_d <= S_DRAIN);
        fetch_d  = (state_d == S_RUN);
        done_d   = ((state_d == S_RUN) && (state_q == S_RST_REL)) ||
                   ((state_d == S_OFF) && (state_q == S_PWR_OFF));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_OFF;
            cnt_q       <= '0;
            boot_addr_q <= '0;
            byp_q       <= 1'b0;
            ack_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            pow_q       <= 1'b0;
            clk_en_q    <= 1'b0;
            rstn_q      <= 1'b0;
            fetch_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            boot_addr_q <= boot_addr_d;
            byp_q       <= byp_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
            err_q       <= err_d;
            pow_q       <= pow_d;
            clk_en_q    <= clk_en_d;
            rstn_q      <= rstn_d;
            fetch_q     <= fetch_d;
        end
    end

    assign cluster_pow_o          = pow_q;
    assign cluster_clk_en_o       = clk_en_q;
    assign cluster_rstn_o         = rstn_q;
    assign cluster_fetch_enable_o = fetch_q;
    assign cluster_boot_addr_o    = boot_addr_q;
    assign cluster_byp_o          = byp_q;
    assign req_ack_o              = ack_q;
    assign done_evt_o             = done_q;
    assign err_o                  = err_q;
    assign state_o                = state_q;

endmodule
